seg_scan_driver: RTL and testbench

Parametrised multiplexed seven-segment display driver for DIGITS common-anode digits. It captures a binary value on a load strobe and converts it to BCD with a sequential shift-add-3 engine. It then time-multiplexes the digits with an all-off gap phase between consecutive digits to suppress ghosting. It sits between datapath counters/registers and the board anode/segment pins and generalises the fixed 4-digit, free-running scanner.

---
 rtl/seg_scan_driver.sv | 197 +++++++++++++++++++
 tb/tb_seg_scan_driver.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// seg_scan_driver
//   Multiplexed seven-segment driver for DIGITS common-anode digits.
//   A load strobe captures in_val. A sequential shift-add-3 engine converts it
//   to BCD, one bit per cycle. The display register then commits atomically.
//   The scanner walks ACT(i)/GAP(i) phase pairs from the top digit down. Each
//   GAP phase keeps every anode off so the previous digit does not ghost into
//   the next one.
//
// Parameters
//   DIGITS       displayed digits (1..8)
//   IN_W         binary input width (4..27)
//   REFRESH_DIV  clk cycles per scan phase (>=2)
//
// Ports
//   clk     system clock, rising edge
//   reset   asynchronous active-low reset
//   in_val  unsigned binary value, captured on load while idle
//   load    start a conversion (ignored while busy)
//   blank   force all anodes off
//   busy    conversion in progress
//   an      active-low anodes, an[i] = decimal weight 10^i
//   seg     active-low segments {g,f,e,d,c,b,a}
//
// Build option
//   LZ_BLANK_EN  when defined, leading zeros are suppressed (digit 0 is always shown)
module seg_scan_driver #(
  parameter int DIGITS      = 4,
  parameter int IN_W        = 16,
  parameter int REFRESH_DIV = 50000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IN_W-1:0]   in_val,
  input  logic              load,
  input  logic              blank,
  output logic              busy,
  output logic [DIGITS-1:0] an,
  output logic [6:0]        seg
);

  localparam int BCD_N = (IN_W * 3) / 10 + 1;
  // One spare zero nibble above the display, so the overflow slice is never empty.
  localparam int EXT_N = ((BCD_N > DIGITS) ? BCD_N : DIGITS) + 1;
  localparam int CW    = $clog2(IN_W + 1);
  localparam int DW    = $clog2(REFRESH_DIV);
  localparam int IW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [6:0] DASH = 7'b0111111;
  localparam logic [6:0] DARK = 7'h7F;

  typedef enum logic {ACT, GAP} mode_t;

  function automatic logic [6:0] dec(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return DARK;
    endcase
  endfunction

  // ---------------- binary -> BCD converter ----------------
  logic [IN_W-1:0]        bin;
  logic [BCD_N*4-1:0]     bcd, bcd_adj, bcd_nxt;
  logic [EXT_N*4-1:0]     bcd_ext;
  logic [CW-1:0]          shifts;
  logic [DIGITS-1:0][3:0] disp;
  logic                   ovf;
  logic                   last;

  always_comb begin
    bcd_adj = bcd;
    for (int k = 0; k < BCD_N; k++)
      if (bcd[k*4 +: 4] >= 4'd5) bcd_adj[k*4 +: 4] = bcd[k*4 +: 4] + 4'd3;
  end

  assign bcd_nxt = {bcd_adj[BCD_N*4-2:0], bin[IN_W-1]};

  always_comb begin
    bcd_ext = '0;
    bcd_ext[BCD_N*4-1:0] = bcd_nxt;
  end

  // The final shift and the commit share one edge, so busy is high for exactly IN_W cycles.
  assign last = (shifts == CW'(IN_W - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy   <= 1'b0;
      bin    <= '0;
      bcd    <= '0;
      shifts <= '0;
      disp   <= '0;
      ovf    <= 1'b0;
    end else if (busy) begin
      bin    <= bin << 1;
      bcd    <= bcd_nxt;
      shifts <= shifts + 1'b1;
      if (last) begin
        busy <= 1'b0;
        disp <= bcd_ext[DIGITS*4-1:0];
        ovf  <= |bcd_ext[EXT_N*4-1:DIGITS*4];
      end
    end else if (load) begin
      bin    <= in_val;
      bcd    <= '0;
      shifts <= '0;
      busy   <= 1'b1;
    end
  end

  // ---------------- refresh divider ----------------
  logic [DW-1:0] div;
  logic          tick;
  logic          blank_r;

  assign tick = (div == DW'(REFRESH_DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div     <= '0;
      blank_r <= 1'b0;
    end else begin
      div     <= tick ? '0 : div + 1'b1;
      blank_r <= blank;
    end
  end

  // ---------------- leading-zero map ----------------
  logic [DIGITS-1:0] lz;
`ifdef LZ_BLANK_EN
  always_comb begin
    logic zacc;
    zacc = 1'b1;
    lz   = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zacc  = zacc & (disp[i] == 4'd0);
      lz[i] = zacc & (i != 0);
    end
  end
`else
  assign lz = '0;
`endif

  // ---------------- scan FSM ----------------
  mode_t             mode, mode_nxt;
  logic [IW-1:0]     idx, idx_nxt;
  logic [DIGITS-1:0] an_r, an_nxt;
  logic [6:0]        seg_r, seg_nxt;

  always_comb begin
    mode_nxt = mode;
    idx_nxt  = idx;
    if (tick) begin
      if (blank_r) begin
        mode_nxt = GAP;
        idx_nxt  = '0;
      end else if (mode == ACT) begin
        mode_nxt = GAP;
      end else begin
        mode_nxt = ACT;
        idx_nxt  = (idx == '0) ? IW'(DIGITS - 1) : idx - 1'b1;
      end
    end
    // The pattern is taken from the display register when the phase is entered.
    // A commit in mid-frame therefore appears at the next phase boundary.
    an_nxt = '1;
    if (mode_nxt == ACT) an_nxt[idx_nxt] = 1'b0;
    if (ovf)               seg_nxt = DASH;
    else if (lz[idx_nxt])  seg_nxt = DARK;
    else                   seg_nxt = dec(disp[idx_nxt]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode  <= GAP;
      idx   <= '0;
      an_r  <= '1;
      seg_r <= DARK;
    end else if (tick) begin
      mode  <= mode_nxt;
      idx   <= idx_nxt;
      an_r  <= an_nxt;
      seg_r <= seg_nxt;
    end
  end

  assign an  = blank_r ? '1 : an_r;
  assign seg = seg_r;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver with DIGITS=4, IN_W=16, REFRESH_DIV=4.
// A behavioural model tracks the divider count, the phase number within the frame,
// the countdown of the pending conversion and the shown integer value. It derives
// segment patterns by decimal arithmetic on that value. A compare process checks
// an/seg/busy one time unit after every rising edge. Directed sequences pin
// hand-computed literals, and a random section mixes loads, overlapping loads and blanking.
module tb_seg_scan_driver;
  localparam int D = 4;
  localparam int W = 16;
  localparam int R = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] in_val = '0;
  logic         load = 1'b0;
  logic         blank = 1'b0;
  logic         busy;
  logic [D-1:0] an;
  logic [6:0]   seg;

  always #5 clk = ~clk;

  seg_scan_driver #(.DIGITS(D), .IN_W(W), .REFRESH_DIV(R)) dut (
    .clk(clk), .reset(reset), .in_val(in_val), .load(load), .blank(blank),
    .busy(busy), .an(an), .seg(seg)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [6:0] seg_tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  function automatic logic [6:0] pat(input int v, input int i);
    int p10 = 1;
    for (int j = 0; j < i; j++) p10 *= 10;
    if (v >= 10000) return 7'b0111111;
`ifdef LZ_BLANK_EN
    if (i > 0 && v < p10) return 7'h7F;
`endif
    return seg_tbl[(v / p10) % 10];
  endfunction

  int         m_div = 0;
  int         m_k = 2 * D - 1;   // phase number in frame: even = ACT, odd = GAP
  int         m_busy = 0;
  int         m_pend = 0;
  int         m_val = 0;
  bit         m_blank_r = 1'b0;
  logic [3:0] m_an_r = 4'hF;
  logic [6:0] m_seg = 7'h7F;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_div = 0; m_k = 2 * D - 1; m_busy = 0; m_val = 0;
      m_blank_r = 1'b0; m_an_r = 4'hF; m_seg = 7'h7F;
    end else begin
      if (m_div == R - 1) begin
        int dig;
        m_div = 0;
        m_k = m_blank_r ? 2 * D - 1 : (m_k + 1) % (2 * D);
        dig = D - 1 - m_k / 2;
        m_an_r = (m_k % 2 == 0) ? ~(4'b0001 << dig) : 4'hF;
        m_seg = pat(m_val, dig);
      end else begin
        m_div++;
      end
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) m_val = m_pend;
      end else if (load) begin
        m_busy = W;
        m_pend = int'(in_val);
      end
      m_blank_r = blank;
    end
  end

  always @(posedge clk) begin
    #1;
    chk("cyc_an", 32'(an), 32'(m_blank_r ? 4'hF : m_an_r));
    chk("cyc_seg", 32'(seg), 32'(m_seg));
    chk("cyc_busy", 32'(busy), 32'(m_busy > 0));
  end

  // ---------------- helpers ----------------
  task automatic wait_an(input logic [3:0] t, input string name);
    int n = 0;
    do begin @(posedge clk); #1; n++; end while (an !== t && n < 400);
    chk(name, 32'(an), 32'(t));
  endtask

  task automatic wait_not_f(input string name);
    int n = 0;
    do begin @(posedge clk); #1; n++; end while (an === 4'hF && n < 400);
    chk(name, 32'(an), 32'(4'b0111));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin @(posedge clk); #1; n++; end
    chk("idle", 32'(busy), 32'd0);
  endtask

  // Skip past the current ACT(0) so that the next frame uses freshly committed data.
  task automatic sync_frame();
    int n = 0;
    wait_an(4'b1110, "sync");
    while (an === 4'b1110 && n < 100) begin @(posedge clk); #1; n++; end
  endtask

  task automatic show(input string name, input logic [6:0] s3, input logic [6:0] s2,
                      input logic [6:0] s1, input logic [6:0] s0);
    wait_an(4'b0111, {name, "_an3"}); chk({name, "_d3"}, 32'(seg), 32'(s3));
    wait_an(4'b1011, {name, "_an2"}); chk({name, "_d2"}, 32'(seg), 32'(s2));
    wait_an(4'b1101, {name, "_an1"}); chk({name, "_d1"}, 32'(seg), 32'(s1));
    wait_an(4'b1110, {name, "_an0"}); chk({name, "_d0"}, 32'(seg), 32'(s0));
  endtask

  task automatic load_count(input int v, output int n);
    @(negedge clk); in_val = W'(v); load = 1'b1;
    @(posedge clk); #1; load = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 50) begin n++; @(posedge clk); #1; end
  endtask

`ifdef LZ_BLANK_EN
  localparam logic [6:0] LZ = 7'h7F;
`else
  localparam logic [6:0] LZ = 7'h40;
`endif

  // ---------------- stimulus ----------------
  initial begin
    int n, v;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk); reset = 1'b1;
    wait_an(4'b0111, "first_act3");
    chk("first_seg", 32'(seg), 32'(LZ));

    load_count(1234, n);
    chk("busy_len", 32'(n), 32'd16);
    sync_frame();
    show("v1234", 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001);

    load_count(10000, n);
    sync_frame();
    show("ovf", 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111);
    load_count(9999, n);
    sync_frame();
    show("v9999", 7'h10, 7'h10, 7'h10, 7'h10);
    load_count(7, n);
    sync_frame();
    show("v7", LZ == 7'h7F ? 7'h7F : 7'h40, LZ == 7'h7F ? 7'h7F : 7'h40,
         LZ == 7'h7F ? 7'h7F : 7'h40, 7'b1111000);
    load_count(0, n);
    sync_frame();
    show("v0", LZ, LZ, LZ, 7'b1000000);

    // blank during ACT(2), held across 10 ticks
    wait_an(4'b1011, "pre_blank");
    @(negedge clk); blank = 1'b1;
    @(posedge clk); #1;
    chk("blank_an", 32'(an), 32'hF);
    for (int i = 0; i < 10 * R; i++) begin
      @(posedge clk); #1;
      chk("blank_hold", 32'(an), 32'hF);
    end
    @(negedge clk); blank = 1'b0;
    wait_not_f("unblank_act3");

    // second load while busy is ignored
    @(negedge clk); in_val = W'(42); load = 1'b1;
    @(posedge clk); #1; load = 1'b0;
    for (int i = 1; i < 5; i++) begin @(posedge clk); #1; end
    @(negedge clk); in_val = W'(555); load = 1'b1;
    @(negedge clk); load = 1'b0;
    wait_idle();
    sync_frame();
    show("v42", LZ, LZ, 7'b0011001, 7'b0100100);

    // reset in the middle of a conversion
    @(negedge clk); in_val = W'(555); load = 1'b1;
    @(posedge clk); #1; load = 1'b0;
    for (int i = 1; i < 8; i++) begin @(posedge clk); #1; end
    @(negedge clk); reset = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_an", 32'(an), 32'hF);
    @(negedge clk); @(negedge clk); reset = 1'b1;
    show("after_rst", LZ, LZ, LZ, 7'b1000000);

    // randomized loads, overlapping loads and blank pulses
    for (int it = 0; it < 14; it++) begin
      case ($urandom_range(0, 3))
        0:       v = int'($urandom_range(0, 99));
        1:       v = int'($urandom_range(9990, 10010));
        default: v = int'($urandom_range(0, 65535));
      endcase
      repeat ($urandom_range(0, 20)) @(negedge clk);
      in_val = W'(v); load = 1'b1; blank = ($urandom_range(0, 4) == 0);
      @(negedge clk); load = 1'b0; in_val = W'($urandom);
      repeat ($urandom_range(0, 24)) @(negedge clk);
      load = 1'b1;
      @(negedge clk); load = 1'b0;
      repeat ($urandom_range(10, 50)) @(negedge clk);
      blank = 1'b0;
      repeat (2 * D * R + 10) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
